// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg
//   Shared types and constants for the memory-port arbiter:
//   - arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT, DONE), 2-bit encoding
//   - owner_e     : which requester owns the access (OWNER_FETCH=0, OWNER_DATA=1)
//   - SETTLE_CNT_W: width of the busy-settle down-counter
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick
//   Combinational grant chooser for the memory-port arbiter. Keeps the
//   arbitration policy out of the FSM.
//   Build option: MEM_PORT_ARB_RR_EN selects round-robin between the two
//   sides when both request; otherwise data has fixed priority over fetch.
//   Ports:
//     ifetch_req  in  fetch side request
//     data_req    in  data side request
//     last_grant  in  owner of the most recently completed access
//     grant_valid out at least one request pending
//     grant_owner out side that would be granted
module arb_pick
  import mem_port_arb_pkg::*;
(
  input  logic   ifetch_req,
  input  logic   data_req,
  input  owner_e last_grant,
  output logic   grant_valid,
  output owner_e grant_owner
);

`ifdef MEM_PORT_ARB_RR_EN
  always_comb begin
    grant_valid = ifetch_req | data_req;
    grant_owner = OWNER_FETCH;
    if (ifetch_req && data_req) begin
      // Contention: hand the port to whoever did not have it last.
      grant_owner = (last_grant == OWNER_DATA) ? OWNER_FETCH : OWNER_DATA;
    end else if (data_req) begin
      grant_owner = OWNER_DATA;
    end
  end
`else
  // Fixed priority: last_grant is tracked by the FSM but not consulted here.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = ifetch_req | data_req;
    grant_owner = data_req ? OWNER_DATA : OWNER_FETCH;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory-controller port between the instruction-fetch side and
//   the data side of the MMU. Requests are serialised, the command is held
//   stable while the controller works, and read data is returned to the
//   owner together with a one-cycle ack pulse.
//   Build option: MEM_PORT_ARB_RR_EN (see arb_pick) enables round-robin
//   arbitration; default is data-over-fetch fixed priority.
//   Parameters: BUSY_SETTLE (1..15 cycles before dev_mem_busy is trusted),
//               ADDR_W, DATA_W.
//   Ports:
//     clk, rst (asynchronous, active-low)
//     ifetch_req/ifetch_addr -> ifetch_rdata/ifetch_ack
//     data_req/data_is_write/data_addr/data_wdata -> data_rdata/data_ack
//     dev_mem_addr/dev_mem_data_out/dev_mem_is_write -> controller
//     dev_mem_data_in/dev_mem_busy <- controller
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int BUSY_SETTLE = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifetch_req,
  input  logic [ADDR_W-1:0] ifetch_addr,
  output logic [DATA_W-1:0] ifetch_rdata,
  output logic              ifetch_ack,
  input  logic              data_req,
  input  logic              data_is_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ack,
  output logic [ADDR_W-1:0] dev_mem_addr,
  output logic [DATA_W-1:0] dev_mem_data_out,
  output logic              dev_mem_is_write,
  input  logic [DATA_W-1:0] dev_mem_data_in,
  input  logic              dev_mem_busy
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(BUSY_SETTLE);
  localparam logic [SETTLE_CNT_W-1:0] CNT_ONE     = SETTLE_CNT_W'(1);

  arb_state_e              state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  owner_e                  owner_q, owner_d;
  owner_e                  last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]       cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]       cmd_wdata_q, cmd_wdata_d;
  logic                    cmd_wr_q, cmd_wr_d;
  logic [DATA_W-1:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]       d_rdata_q, d_rdata_d;

  logic   grant_valid;
  owner_e grant_owner;

  arb_pick u_pick (
    .ifetch_req  (ifetch_req),
    .data_req    (data_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    cmd_addr_d       = cmd_addr_q;
    cmd_wdata_d      = cmd_wdata_q;
    cmd_wr_d         = cmd_wr_q;
    if_rdata_d       = if_rdata_q;
    d_rdata_d        = d_rdata_q;
    ifetch_ack       = 1'b0;
    data_ack         = 1'b0;
    dev_mem_is_write = 1'b0;

    case (state_q)
      IDLE: begin
        // A busy controller blocks new grants; the request simply waits.
        if (grant_valid && !dev_mem_busy) begin
          owner_d = grant_owner;
          if (grant_owner == OWNER_DATA) begin
            cmd_addr_d  = data_addr;
            cmd_wdata_d = data_wdata;
            cmd_wr_d    = data_is_write;
          end else begin
            cmd_addr_d  = ifetch_addr;
            cmd_wdata_d = '0;
            cmd_wr_d    = 1'b0;
          end
          cnt_d   = SETTLE_LOAD;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // Controller's busy response is not yet valid here, so it is ignored.
        dev_mem_is_write = cmd_wr_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (cnt_q <= CNT_ONE) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        dev_mem_is_write = cmd_wr_q;
        if (!dev_mem_busy) begin
          // Writes also capture the bus; the requester treats it as don't-care.
          if (owner_q == OWNER_DATA) begin
            d_rdata_d = dev_mem_data_in;
          end else begin
            if_rdata_d = dev_mem_data_in;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        ifetch_ack   = (owner_q == OWNER_FETCH);
        data_ack     = (owner_q == OWNER_DATA);
        last_grant_d = owner_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= OWNER_FETCH;
      last_grant_q <= OWNER_FETCH;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_wr_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_wr_q     <= cmd_wr_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign dev_mem_addr     = cmd_addr_q;
  assign dev_mem_data_out = cmd_wdata_q;
  assign ifetch_rdata     = if_rdata_q;
  assign data_rdata       = d_rdata_q;

endmodule
